// File: rtl/column_hamming_pkg.sv
// ============================================================================
// Module  : column_hamming_pkg
// Brief   : Widths, parity masks and types for the Hamming(10,6) column code.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package column_hamming_pkg;

    localparam int COL_DATA_W = 6;
    localparam int COL_CODE_W = 10;

    // Each mask selects the data bits whose decoder position sets that syndrome bit
    localparam logic [COL_DATA_W-1:0] P0_MASK = 6'b011011;
    localparam logic [COL_DATA_W-1:0] P1_MASK = 6'b101101;
    localparam logic [COL_DATA_W-1:0] P2_MASK = 6'b001110;
    localparam logic [COL_DATA_W-1:0] P3_MASK = 6'b110000;

    typedef logic [COL_DATA_W-1:0] col_data_t;
    typedef logic [COL_CODE_W-1:0] col_code_t;

endpackage

`default_nettype wire

// File: rtl/column_hamming_enc.sv
// ============================================================================
// Module  : column_hamming_enc
// Brief   : Combinational 6->10 Hamming encoder, code = {p3,p2,p1,p0,d[5:0]}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module column_hamming_enc
    import column_hamming_pkg::*;
(
    input  logic [COL_DATA_W-1:0] i_data,
    output logic [COL_CODE_W-1:0] o_code
);

    assign o_code = {^(i_data & P3_MASK),
                     ^(i_data & P2_MASK),
                     ^(i_data & P1_MASK),
                     ^(i_data & P0_MASK),
                     i_data};

endmodule

`default_nettype wire

// File: rtl/column_hamming_enc_fifo.sv
// ============================================================================
// Module  : column_hamming_enc_fifo
// Brief   : Encodes column addresses and buffers code words in an FWFT FIFO.
//           Define COLUMN_HAMMING_ERR_INJ_EN to add single-bit error injection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module column_hamming_enc_fifo
    import column_hamming_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [COL_DATA_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COL_CODE_W-1:0] out_code,
    output logic [CNT_W-1:0]      count
`ifdef COLUMN_HAMMING_ERR_INJ_EN
   ,input  logic                  inj_en,
    input  logic [3:0]            inj_pos
`endif
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    col_code_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    col_code_t w_enc_code;
    col_code_t w_err_mask;
    col_code_t w_wr_code;
    logic      w_push;
    logic      w_pop;

    column_hamming_enc u_enc (
        .i_data (in_data),
        .o_code (w_enc_code)
    );

`ifdef COLUMN_HAMMING_ERR_INJ_EN
    assign w_err_mask = (inj_en && (inj_pos < 4'd10)) ? (col_code_t'(1) << inj_pos) : '0;
`else
    assign w_err_mask = '0;
`endif

    assign w_wr_code = w_enc_code ^ w_err_mask;

    // Flags come from the registered count only, so no input reaches an output combinationally
    assign in_ready  = (r_count != C_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign out_code  = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_wr_code;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_column_hamming_enc_fifo.sv
// ============================================================================
// Module  : tb_column_hamming_enc_fifo
// Brief   : Self-checking bench against a queue model and positional Hamming code.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_column_hamming_enc_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             clear     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [5:0]       in_data   = '0;
    logic             in_ready;
    logic             out_valid;
    logic [9:0]       out_code;
    logic [CNT_W-1:0] count;
`ifdef COLUMN_HAMMING_ERR_INJ_EN
    logic             inj_en    = 1'b0;
    logic [3:0]       inj_pos   = '0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [9:0] q_code [$];
    logic [5:0] q_data [$];

    column_hamming_enc_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .count     (count)
`ifdef COLUMN_HAMMING_ERR_INJ_EN
       ,.inj_en    (inj_en),
        .inj_pos   (inj_pos)
`endif
    );

    always #5 clk = ~clk;

    // Parity bits are the syndrome of the data bits at their codeword positions
    function automatic logic [9:0] ref_enc(input logic [5:0] d);
        int         pos [6] = '{3, 5, 6, 7, 9, 10};
        logic [3:0] s       = '0;
        for (int i = 0; i < 6; i++) if (d[i]) s ^= 4'(pos[i]);
        return {s, d};
    endfunction

    function automatic logic [5:0] ref_dec(input logic [9:0] c);
        int pos [10] = '{3, 5, 6, 7, 9, 10, 1, 2, 4, 8};
        int s        = 0;
        for (int i = 0; i < 10; i++) if (c[i]) s ^= pos[i];
        for (int i = 0; i < 10; i++) if (s != 0 && pos[i] == s) c[i] = ~c[i];
        return c[5:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, then clock once and advance the model
    task automatic tick();
        bit         push;
        bit         pop;
        logic [9:0] injm = '0;
        check("count", 16'(count), 16'(q_code.size()));
        check("out_valid", 16'(out_valid), 16'(q_code.size() != 0));
        check("in_ready", 16'(in_ready), 16'(q_code.size() != DEPTH));
        if (q_code.size() != 0) begin
            check("out_code", 16'(out_code), 16'(q_code[0]));
            check("decode", 16'(ref_dec(out_code)), 16'(q_data[0]));
        end
`ifdef COLUMN_HAMMING_ERR_INJ_EN
        if (inj_en && inj_pos < 10) injm[inj_pos] = 1'b1;
`endif
        push = in_valid && (q_code.size() < DEPTH);
        pop  = out_ready && (q_code.size() != 0);
        @(posedge clk);
        if (clear) begin
            q_code.delete();
            q_data.delete();
        end else begin
            if (pop) begin
                void'(q_code.pop_front());
                void'(q_data.pop_front());
            end
            if (push) begin
                q_code.push_back(ref_enc(in_data) ^ injm);
                q_data.push_back(in_data);
            end
        end
        #1;
    endtask

    logic [5:0] enc_d   [4] = '{6'h00, 6'h3F, 6'h01, 6'h0A};
    logic [9:0] enc_exp [4] = '{10'h000, 10'h13F, 10'h0C1, 10'h08A};

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_count", 16'(count), 16'd0);
        check("rst_out_code", 16'(out_code), 16'h000);
        reset_n = 1'b1;
        tick();

        // Encoding of known addresses
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = enc_d[i];
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("enc_literal", 16'(out_code), 16'(enc_exp[i]));
            tick();
        end

        // Full and backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_data = 6'($urandom);
            tick();
        end
        check("full_count", 16'(count), 16'(DEPTH));
        check("full_in_ready", 16'(in_ready), 16'd0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (DEPTH) tick();

        // Simultaneous push and pop at count=2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (2) begin
            in_data = 6'($urandom);
            tick();
        end
        out_ready = 1'b1;
        in_data   = 6'($urandom);
        tick();
        check("simul_count", 16'(count), 16'd2);
        in_valid = 1'b0;
        repeat (3) tick();

        // Clear at count=3 with push and pop asserted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin
            in_data = 6'($urandom);
            tick();
        end
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_count", 16'(count), 16'd0);
        check("clear_out_valid", 16'(out_valid), 16'd0);

        // Round trip of every address
        for (int d = 0; d < 64; d++) begin
            in_data = 6'(d);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // Asynchronous reset in the middle of a transfer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (2) begin
            in_data = 6'($urandom_range(1, 63));
            tick();
        end
        reset_n = 1'b0;
        #2;
        check("midrst_count", 16'(count), 16'd0);
        check("midrst_out_valid", 16'(out_valid), 16'd0);
        check("midrst_in_ready", 16'(in_ready), 16'd1);
        check("midrst_out_code", 16'(out_code), 16'h000);
        q_code.delete();
        q_data.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

`ifdef COLUMN_HAMMING_ERR_INJ_EN
        // Single-bit injection, then an out-of-range position
        in_valid = 1'b1;
        in_data  = 6'h01;
        inj_en   = 1'b1;
        inj_pos  = 4'd2;
        tick();
        inj_pos  = 4'd12;
        tick();
        inj_en   = 1'b0;
        in_valid = 1'b0;
        check("inj_code", 16'(out_code), 16'h0C5);
        check("inj_decode", 16'(ref_dec(out_code)), 16'h01);
        out_ready = 1'b1;
        tick();
        check("inj_off_range", 16'(out_code), 16'h0C1);
        repeat (2) tick();
`endif

        // Randomized traffic with occasional clears
        for (int n = 0; n < 400; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 6'($urandom);
            clear     = ($urandom_range(0, 29) == 0);
`ifdef COLUMN_HAMMING_ERR_INJ_EN
            inj_en    = 1'($urandom_range(0, 1));
            inj_pos   = 4'($urandom);
`endif
            tick();
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 1) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
